// File: rtl/csa_resolve_adder.sv
// rtl/csa_resolve_adder.sv - two-stage carry-propagate resolver for 4:2 compressor sum/carry vectors
module csa_resolve_adder #(
    parameter int WIDTH     = 48,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     sum_i,
    input  logic [WIDTH-1:0]     carry_i,
    input  logic                 cin_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     res_o,
    output logic                 cout_o,
    output logic [TAG_WIDTH-1:0] tag_o
);
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    logic                 s1_valid;
    logic [LO-1:0]        s1_lo;
    logic                 s1_clo;
    logic [HI-1:0]        s1_sum_hi;
    logic [HI:0]          s1_carry_hi;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic        s2_accept;
    logic        s1_advance;
    logic        in_accept;
    logic [LO:0] lo_total;
    logic [HI:0] hi_total;

    assign s2_accept  = !out_valid_o || out_ready_i;
    assign s1_advance = s1_valid && s2_accept;
    assign in_ready_o = !s1_valid || s2_accept;
    assign in_accept  = in_valid_i && in_ready_o;

    // carry_i is one bit left of sum_i, so cin fills the vacated LSB slot
    assign lo_total = {1'b0, sum_i[LO-1:0]} + {1'b0, carry_i[LO-2:0], cin_i};
    // bit HI is cout; the final carry (weight 2^(WIDTH+1)) falls off the top
    assign hi_total = {1'b0, s1_sum_hi} + s1_carry_hi + {{HI{1'b0}}, s1_clo};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid    <= 1'b0;
            s1_lo       <= '0;
            s1_clo      <= 1'b0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
            s1_tag      <= '0;
        end else begin
            if (flush_i) begin
                s1_valid <= 1'b0;
            end else if (in_accept) begin
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (in_accept) begin
                s1_lo       <= lo_total[LO-1:0];
                s1_clo      <= lo_total[LO];
                s1_sum_hi   <= sum_i[WIDTH-1:LO];
                s1_carry_hi <= carry_i[WIDTH-1:LO-1];
                s1_tag      <= tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            res_o       <= '0;
            cout_o      <= 1'b0;
            tag_o       <= '0;
        end else begin
            if (flush_i) begin
                out_valid_o <= 1'b0;
            end else if (s1_advance) begin
                out_valid_o <= 1'b1;
            end else if (s2_accept) begin
                out_valid_o <= 1'b0;
            end
            if (s1_advance) begin
                res_o  <= {hi_total[HI-1:0], s1_lo};
                cout_o <= hi_total[HI];
                tag_o  <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_csa_resolve_adder.sv
// tb/tb_csa_resolve_adder.sv - self-checking bench for csa_resolve_adder (WIDTH=8, TAG_WIDTH=4)
module tb_csa_resolve_adder;
    localparam int W  = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  sum = '0;
    logic [W-1:0]  carry = '0;
    logic          cin = 1'b0;
    logic [TW-1:0] tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  res;
    logic          cout;
    logic [TW-1:0] tag_out;

    csa_resolve_adder #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sum_i(sum), .carry_i(carry), .cin_i(cin), .tag_i(tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .res_o(res), .cout_o(cout), .tag_o(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  sum;
        logic [W-1:0]  carry;
        logic          cin;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp_res;
        logic          exp_cout;
    } vec_t;

    typedef struct {
        logic [W-1:0]  res;
        logic          cout;
        logic [TW-1:0] tag;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   sent = 0;
    int   recvd = 0;
    exp_t exp_q[$];
    logic          hold_prev = 1'b0;
    logic [W-1:0]  prev_res;
    logic          prev_cout;
    logic [TW-1:0] prev_tag;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact arithmetic total, then split into result and cout
    function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c,
                                   input logic ci, input logic [TW-1:0] t);
        int   total;
        exp_t e;
        total  = int'(s) + 2 * int'(c) + int'(ci);
        e.res  = W'(total % (1 << W));
        e.cout = ((total >> W) & 1) != 0;
        e.tag  = t;
        return e;
    endfunction

    task automatic sample();
        exp_t e;
        if (hold_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_res", 32'(res), 32'(prev_res));
            chk("hold_cout", 32'(cout), 32'(prev_cout));
            chk("hold_tag", 32'(tag_out), 32'(prev_tag));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(res), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_res", 32'(res), 32'(e.res));
                chk("sb_cout", 32'(cout), 32'(e.cout));
                chk("sb_tag", 32'(tag_out), 32'(e.tag));
            end
            recvd++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(sum, carry, cin, tag));
            sent++;
        end
        hold_prev = out_valid && !out_ready;
        prev_res  = res;
        prev_cout = cout;
        prev_tag  = tag_out;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input logic [TW-1:0] t);
        sum   = W'($urandom);
        carry = W'($urandom);
        cin   = 1'($urandom);
        tag   = t;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("sent_vs_recvd", 32'(recvd), 32'(sent));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        sum = v.sum; carry = v.carry; cin = v.cin; tag = v.tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_res"}, 32'(res), 32'(v.exp_res));
        chk({name, "_cout"}, 32'(cout), 32'(v.exp_cout));
        chk({name, "_tag"}, 32'(tag_out), 32'(v.tag));
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 4'h3, 8'h11, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 4'h1, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h80, 1'b0, 4'h2, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'h80, 1'b1, 4'h4, 8'h00, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 1'b1, 4'h5, 8'h55, 1'b1};
        vecs[5] = '{8'h80, 8'h40, 1'b0, 4'h6, 8'h00, 1'b1};
        vecs[6] = '{8'h08, 8'h04, 1'b0, 4'h7, 8'h10, 1'b0};
        vecs[7] = '{8'h07, 8'h00, 1'b1, 4'hE, 8'h08, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Streaming then backpressure, scoreboard-checked
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_payload(TW'(i));
            in_valid = 1'b1;
            step();
        end
        drain();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_payload(4'h7);
        step();
        rand_payload(4'h8);
        step();
        rand_payload(4'h9);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        sample();
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
        step();
        drain();
        chk("stream_count", 32'(recvd), 32'd9);

        // Flush with two ops in flight plus one presented during the flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum = 8'h12; carry = 8'h34; cin = 1'b0; tag = 4'hA;
        @(posedge clk); #1;
        sum = 8'h56; carry = 8'h78; tag = 4'hB;
        @(posedge clk); #1;
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        sum = 8'h9A; tag = 4'hC;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum = 8'h0F; carry = 8'h01; cin = 1'b0; tag = 4'h5;
        @(posedge clk); #1;
        sum = 8'h33; tag = 4'h6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_res", 32'(res), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_tag", 32'(tag_out), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_ghost", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_vec(vecs[4], "post_rst");

        // Constrained-random traffic against the reference model
        sent = 0;
        recvd = 0;
        hold_prev = 1'b0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            rand_payload(TW'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("rand_sent", 32'(sent), 32'd10000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csa_resolve_adder.md
# csa_resolve_adder

Pipelined carry-propagate stage that resolves the redundant sum/carry vectors produced by a row of 4:2 compressor cells into a single binary result. It sits directly downstream of the compressor array in the FPU mantissa datapath and feeds normalization/rounding. It is a two-stage pipeline with valid/ready handshakes on both sides, full throughput, and backpressure propagation.

## Interface
- WIDTH, 48: width of the sum/carry vectors and of the result; even, >= 4.
- TAG_WIDTH, 4: width of the sideband tag carried alongside each operation; >= 1.
- LO_WIDTH (derived, WIDTH/2): width of the stage-1 lower slice.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; drops all in-flight operations.
- in_valid_i  in  1  sum_i/carry_i/cin_i/tag_i valid.
- in_ready_o  out  1  stage 1 can accept this cycle.
- sum_i  in  WIDTH  compressor S vector; bit k has weight 2^k.
- carry_i  in  WIDTH  compressor C vector; bit k has weight 2^(k+1).
- cin_i  in  1  injected carry, weight 2^0 (row-LSB E_in).
- tag_i  in  TAG_WIDTH  opaque sideband, returned unchanged.
- out_valid_o  out  1  res_o/cout_o/tag_o valid.
- out_ready_i  in  1  consumer accepts this cycle.
- res_o  out  WIDTH  resolved result.
- cout_o  out  1  bit WIDTH of the exact sum.
- tag_o  out  TAG_WIDTH  tag of the result.

## Operation
- Arithmetic: the exact total is T = sum_i + 2*carry_i + cin_i, computed at WIDTH+2 bits. res_o = T[WIDTH-1:0] and cout_o = T[WIDTH]. T[WIDTH+1] is discarded.
- Stage 1 (on accept):
  - Add the lower LO_WIDTH bits: sum_i[LO-1:0] + {carry_i[LO-2:0], cin_i}.
  - Register the LO_WIDTH-bit low result and its carry-out c_lo.
  - Register the upper operand slices: sum_i[W-1:LO] and carry_i[W-1:LO-1], as WIDTH-LO+1 bits.
  - Register the tag and set s1_valid.
- Stage 2 (on advance):
  - Add the upper slices with c_lo: {1'b0, sum_hi} + carry_hi_shifted + c_lo, where carry_hi_shifted = carry_i[W-1:LO-1] aligned so that carry_i[LO-1] lands at weight 2^LO.
  - Register the upper WIDTH-LO bits and the next bit into cout_o.
  - Pass the low result and tag through, and set out_valid_o.
- Handshake rules:
  - s2_accept = !out_valid_o || out_ready_i.
  - s1_advance = s1_valid && s2_accept.
  - in_ready_o = !s1_valid || s2_accept. This is combinational from out_ready_i.
  - A transfer occurs when valid && ready are both high in the same cycle.
  - Output payload must be held stable while out_valid_o=1 && out_ready_i=0.
  - Stage registers load only on their accept/advance; otherwise they hold.
- Simultaneous accept and advance in one cycle is legal and sustains 1 op/cycle.
- flush_i=1 clears s1_valid and out_valid_o next edge, regardless of handshake. in_ready_o is still driven normally, but any input accepted in a flush cycle is dropped. Payload registers may hold stale data.

## Timing
- Reset (rst_ni=0, asynchronous): s1_valid=0, out_valid_o=0, res_o=0, cout_o=0, tag_o=0. Therefore in_ready_o=1 during reset.
- Latency: 2 cycles. Input accepted at edge n appears with out_valid_o=1 after edge n+1, given no stall.
- Throughput: 1 op/cycle when out_ready_i is held 1.
- Stall: with out_ready_i=0 and both stages full, in_ready_o=0. When out_ready_i rises, in_ready_o rises in the same cycle.
- Reset asserted mid-operation: all in-flight ops are lost and no output is produced for them. After rst_ni rises, the first accept obeys normal latency.
- No combinational path exists from inputs to res_o/cout_o/tag_o/out_valid_o. The only combinational path is out_ready_i to in_ready_o.

## Test plan
All scenarios use WIDTH=8 (LO_WIDTH=4) and TAG_WIDTH=4.
- Basic: sum_i=0x0F, carry_i=0x01, cin_i=0, tag_i=0x3 -> two cycles later res_o=0x11, cout_o=0, tag_o=0x3.
- Carry across the slice boundary: sum_i=0xFF, carry_i=0x00, cin_i=1 -> res_o=0x00, cout_o=1.
- MSB carry weight: sum_i=0x00, carry_i=0x80, cin_i=0 -> res_o=0x00, cout_o=1. Then sum_i=0xFF, carry_i=0x80, cin_i=1 (total 512) -> res_o=0x00, cout_o=0.
- Throughput/backpressure:
  - Stream 6 ops with out_ready_i=1: results arrive back-to-back, in order, with matching tags.
  - Then drop out_ready_i for 3 cycles: after two more accepts in_ready_o=0, and res_o is held stable.
  - Raise out_ready_i: in_ready_o=1 the same cycle, and no op is lost or duplicated.
- Flush: with two ops in flight, pulse flush_i -> out_valid_o=0 next cycle, and neither op ever appears.
- Reset: assert rst_ni=0 asynchronously with both stages full -> out_valid_o, res_o, cout_o, tag_o go to 0 immediately and in_ready_o=1. Then a post-reset op emerges after 2 cycles.
- Random: constrained-random 10k ops with random out_ready_i; compare against the reference model T = sum + 2*carry + cin.
